// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MemOp encodings, LSU state encoding and store-lane helpers.
// Used by the decoder, the datapath and the load/store unit.
package cpu_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_WR,
    LSU_RD,
    LSU_RDW,
    LSU_RESP
  } lsu_state_e;

  // Access size comes from the low two MemOp bits; any code other than 00/01 is a word.
  function automatic logic mop_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return off == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] mop_wmask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mop_wdata(input logic [1:0] sz, input logic [31:0] data);
    case (sz)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load lane select and sign/zero extension of a 32-bit RAM word.
// Purely combinational so it can be shared with future fetch half-word logic.
module lsu_extract
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  mem_op,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;

  always_comb begin
    shifted   = word >> {off, 3'b000};
    byte_lane = shifted[7:0];
    half_lane = off[1] ? word[31:16] : word[15:0];
    sext      = ~mem_op[2];
    case (mem_op[1:0])
      2'b00:   result = {{24{sext & byte_lane[7]}}, byte_lane};
      2'b01:   result = {{16{sext & half_lane[15]}}, half_lane};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory access per request against a
// synchronous-read word RAM, with a busy/done handshake for pipeline stalls.
module lsu
  import cpu_pkg::*;
#(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              MemWr,
  input  logic [2:0]        MemOp,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       load_val;

  // High address bits alias onto the RAM; they are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:MEM_AW+2];

  lsu_extract u_extract (
    .word   (mem_rdata),
    .off    (off_q),
    .mem_op (op_q),
    .result (load_val)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    op_d       = op_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      LSU_IDLE: begin
        if (req) begin
          addr_d  = addr[MEM_AW+1:2];
          off_d   = addr[1:0];
          op_d    = MemOp;
          wmask_d = mop_wmask(MemOp[1:0], addr[1:0]);
          wdata_d = mop_wdata(MemOp[1:0], wdata);
          if (!mop_aligned(MemOp[1:0], addr[1:0])) begin
            state_d    = LSU_RESP;
            rdata_d    = '0;
            misalign_d = 1'b1;
          end else if (MemWr) begin
            state_d = LSU_WR;
          end else begin
            state_d = LSU_RD;
          end
        end
      end
      LSU_WR: begin
        state_d    = LSU_RESP;
        rdata_d    = '0;
        misalign_d = 1'b0;
      end
      LSU_RD:  state_d = LSU_RDW;
      LSU_RDW: begin
        state_d    = LSU_RESP;
        rdata_d    = load_val;
        misalign_d = 1'b0;
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      op_q       <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      op_q       <= op_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Every output is a register or a decode of the state register.
  assign busy      = (state_q != LSU_IDLE);
  assign done      = (state_q == LSU_RESP);
  assign mem_we    = (state_q == LSU_WR);
  assign mem_re    = (state_q == LSU_RD);
  assign mem_wmask = mem_we ? wmask_q : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU: takes the ALU result as an effective byte address plus the store data and `MemOp`/`MemWr` controls, and performs one RV32I data-memory access against a word-wide synchronous-read RAM. It generates byte-lane masks for stores and performs lane extraction and sign/zero extension for loads. A `busy`/`done` handshake lets the CPU control stall the pipeline for the multi-cycle access.

## Interface
Parameters:
- `MEM_AW`, 15, word-address width of the data RAM (default 32K words = 128 KiB).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `req`  in  1  access request, sampled only while `busy`=0
- `MemWr`  in  1  1 = store, 0 = load
- `MemOp`  in  3  access type: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned (stores use low 2 bits only)
- `addr`  in  32  byte address (ALU `aluresult`)
- `wdata`  in  32  store data (rs2)
- `busy`  out  1  access in progress; `req` ignored
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  32  extended load result, valid while `done`=1
- `misalign`  out  1  alignment fault, valid while `done`=1
- `mem_addr`  out  MEM_AW  RAM word address
- `mem_re`  out  1  RAM read enable
- `mem_we`  out  1  RAM write enable
- `mem_wmask`  out  4  RAM byte write mask, bit i = byte i
- `mem_wdata`  out  32  RAM write data, lane-replicated
- `mem_rdata`  in  32  RAM read data, valid one cycle after `mem_re`

## Operation
- FSM states: IDLE, WR, RD, RDW, RESP.
- IDLE: on `req`=1 latch `addr`, `wdata`, `MemOp`, `MemWr`; check alignment (half: `addr[0]`=0; word: `addr[1:0]`=00; byte always aligned). Misaligned → RESP with fault; store → WR; load → RD.
- WR: `mem_we`=1, `mem_addr`=latched `addr[MEM_AW+1:2]`, mask = 0001<<off (byte), 0011<<off (half), 1111 (word); `mem_wdata` = byte replicated ×4 / half replicated ×2 / word. → RESP.
- RD: `mem_re`=1, `mem_addr` as above. → RDW.
- RDW: capture `mem_rdata`, select lane by `addr[1:0]`, sign-extend if `MemOp[2]`=0 else zero-extend, into `rdata` register. → RESP.
- RESP: `done`=1 for exactly one cycle; `misalign` set only on fault path. → IDLE.
- Address bits above `MEM_AW+1` are discarded (aliasing wrap); no fault.
- Misaligned accesses never assert `mem_we` or `mem_re`.
- `rdata` holds its last value outside `done`; after a store or fault `rdata`=0.
- `MemOp` 011/110/111: treated as word (loads) / low-2-bit decode (stores); no fault.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rdata`=0, `misalign`=0, `mem_re`=0, `mem_we`=0, `mem_wmask`=0, `mem_addr`=0, `mem_wdata`=0.
- All outputs registered or decoded from state register only (no combinational path from `req`/`addr` to any output).
- Accept at edge E0 (IDLE, `req`=1). Store: `mem_we` in cycle after E0, `done` in the cycle after that (latency 2). Load: `mem_re` cycle 1, `mem_rdata` sampled end of cycle 2, `done` cycle 3 (latency 3). Fault: `done`+`misalign` in cycle 1.
- `busy`=1 from the cycle after acceptance through the RESP cycle inclusive; next `req` accepted in the cycle after `done`.
- `req` held high continuously → back-to-back accesses with one IDLE cycle between.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously); no `done` is produced for the aborted access; a store interrupted in WR may or may not have been written.

## Structure
- Shared package `cpu_pkg`: `MemOp` encoding constants (`MOP_B`, `MOP_H`, `MOP_W`, `MOP_BU`, `MOP_HU`) and the LSU state encoding; shared with the decoder and the top-level datapath.
- One sub-module `lsu_extract`: purely combinational lane select + sign/zero extension (`word`, `off[1:0]`, `MemOp` → 32-bit result); reused by any future instruction-fetch half-word logic.

## Test plan
- Store word: `addr`=0x100, `wdata`=0xDEADBEEF, `MemOp`=010 → cycle 1 `mem_we`=1, `mem_addr`=0x40, `mem_wmask`=1111; cycle 2 `done`=1, `misalign`=0.
- Store byte then load signed/unsigned byte: sb 0x80 at 0x103 (mask 1000, `mem_wdata`=0x80808080); lb 0x103 → `rdata`=0xFFFFFF80 at cycle 3; lbu → 0x00000080.
- Half load: RAM word 0x8001_7FFF at 0x200; lh 0x202 → 0xFFFF8001; lhu 0x200 → 0x00007FFF.
- Misalign: lw 0x101 and sh 0x103 → `done`+`misalign`=1 in cycle 1, `mem_re`/`mem_we` never asserted.
- Handshake: `req` held high for 3 loads → each `done` exactly one cycle, one IDLE cycle between, `req` during `busy` ignored (latched address unchanged).
- Reset in RD state → all outputs 0 same cycle, no `done`; new request after reset completes normally.
